instr_fetch_unit: RTL and testbench

- Initiator side of the instruction memory interface.
- Holds the PC and drives Inst_Adress into the combinational, byte-addressed, little-endian instruction memory; captures the returned 32-bit Instruction.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode on a valid/ready handshake.
- Supports redirect (branch/jump) with flush, end-of-program halt, and a misalignment fault.

---
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, fetch FIFO, valid/ready delivery to decode,
// redirect/flush, end-of-program halt and misaligned-redirect fault.
// Optional macro FETCH_COUNT_EN enables the delivered-instruction counter on fetch_count.
//
// state | meaning
// RUN   | fetching sequentially while pc+4 stays within the memory
// END   | fetch ran past the memory end; buffer still drains
// FAULT | misaligned redirect target; buffer empty, no fetch
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          MEM_BYTES  = 12,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Adress,
  input  logic [31:0] Instruction,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [63:0] if_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_RUN, S_END, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic [31:0]   instr_mem_d [FIFO_DEPTH];
  logic [63:0]   pc_mem_q    [FIFO_DEPTH];
  logic [63:0]   pc_mem_d    [FIFO_DEPTH];

  logic [64:0] pc_plus4;
  logic        legal;
  logic        room;
  logic        pop;
  logic        push;
  logic        not_empty;

  // Fetch legality (65-bit so the bound check can never wrap) and handshake terms
  always_comb begin
    pc_plus4  = {1'b0, pc_q} + 65'd4;
    legal     = (pc_plus4 <= 65'(MEM_BYTES));
    not_empty = (count_q != '0);
    if_valid  = not_empty && !redirect_valid;
    pop       = if_valid && if_ready;
    room      = (count_q < CW'(FIFO_DEPTH)) || pop;
    push      = (state_q == S_RUN) && legal && room && !redirect_valid;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // Next-state: redirect wins, otherwise RUN stops at the memory end
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (redirect_pc[1:0] == 2'b00) ? S_RUN : S_FAULT;
    end else if ((state_q == S_RUN) && !legal) begin
      state_d = S_END;
    end
  end

  // State-decoded outputs
  always_comb begin
    halted = (state_q == S_END);
    fault  = (state_q == S_FAULT);
  end

  // PC, occupancy, pointers and buffer contents next values
  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (redirect_pc[1:0] == 2'b00) pc_d = redirect_pc;
    end else begin
      if (push) begin
        instr_mem_d[wr_ptr_q] = Instruction;
        pc_mem_d[wr_ptr_q]    = pc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        pc_d                  = pc_plus4[63:0];
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

  // Memory address and buffer head; head reads as zero when the buffer is empty
  always_comb begin
    Inst_Adress    = pc_q;
    if_instruction = not_empty ? instr_mem_q[rd_ptr_q] : 32'd0;
    if_pc          = not_empty ? pc_mem_q[rd_ptr_q] : 64'd0;
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // Delivered-instruction counter; survives redirects, wraps naturally
  always_comb begin
    fetch_count_d = pop ? fetch_count_q + 32'd1 : fetch_count_q;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) fetch_count_q <= '0;
    else       fetch_count_q <= fetch_count_d;
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit against a 12-byte little-endian program.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] Inst_Adress;
  logic [31:0] Instruction;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [63:0] if_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  int n_cmp;
  int n_err;

  logic [7:0] mem [12];

  localparam logic [31:0] I0 = 32'h005201B3;
  localparam logic [31:0] I1 = 32'h00730133;
  localparam logic [31:0] I2 = 32'h005504B3;

  instr_fetch_unit #(.RESET_PC(64'd0), .MEM_BYTES(12), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .Inst_Adress    (Inst_Adress),
    .Instruction    (Instruction),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational byte-addressed memory; out-of-range words read as zero
  always_comb begin
    Instruction = 32'd0;
    if (Inst_Adress <= 64'd8)
      Instruction = {mem[Inst_Adress[3:0] + 4'd3], mem[Inst_Adress[3:0] + 4'd2],
                     mem[Inst_Adress[3:0] + 4'd1], mem[Inst_Adress[3:0]]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] ins, input logic [63:0] pc);
    chk({tag, "_valid"}, 64'(if_valid), 64'd1);
    chk({tag, "_instr"}, 64'(if_instruction), 64'(ins));
    chk({tag, "_pc"}, if_pc, pc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_count(input string tag, input logic [31:0] exp_on);
`ifdef FETCH_COUNT_EN
    chk(tag, 64'(fetch_count), 64'(exp_on));
`else
    chk(tag, 64'(fetch_count), 64'd0);
`endif
  endtask

  initial begin
    logic [7:0] prog [12];
    prog = '{8'hB3, 8'h01, 8'h52, 8'h00, 8'h33, 8'h01, 8'h73, 8'h00, 8'hB3, 8'h04, 8'h55, 8'h00};
    for (int i = 0; i < 12; i++) mem[i] = prog[i];
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;

    // Test 1: straight-line run with decode always ready
    if_ready = 1'b1;
    do_reset();
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_instr", 64'(if_instruction), 64'd0);
    chk("rst_pc", if_pc, 64'd0);
    chk("rst_addr", Inst_Adress, 64'd0);
    chk_count("rst_cnt", 32'd0);
    cyc();
    head("t1_h0", I0, 64'd0);
    cyc();
    head("t1_h1", I1, 64'd4);
    cyc();
    head("t1_h2", I2, 64'd8);
    chk("t1_run", 64'(halted), 64'd0);
    cyc();
    chk("t1_halted", 64'(halted), 64'd1);
    chk("t1_nvalid", 64'(if_valid), 64'd0);
    chk("t1_addr", Inst_Adress, 64'd12);
    chk_count("t1_cnt", 32'd3);

    // Test 2: backpressure fills the buffer, then drains in order
    if_ready = 1'b0;
    do_reset();
    chk_count("t2_cnt_rst", 32'd0);
    for (int i = 0; i < 5; i++) cyc();
    head("t2_full", I0, 64'd0);
    chk("t2_addr", Inst_Adress, 64'd8);
    if_ready = 1'b1;
    cyc();
    head("t2_h1", I1, 64'd4);
    chk("t2_addr12", Inst_Adress, 64'd12);
    cyc();
    head("t2_h2", I2, 64'd8);
    chk("t2_halt_drain", 64'(halted), 64'd1);
    cyc();
    chk("t2_empty", 64'(if_valid), 64'd0);
    chk_count("t2_cnt", 32'd3);

    // Test 3: redirect to 4 while head is pc 0
    if_ready = 1'b0;
    do_reset();
    cyc();
    head("t3_pre", I0, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 64'd4;
    if_ready = 1'b1;
    #1;
    chk("t3_mask", 64'(if_valid), 64'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("t3_flush", 64'(if_valid), 64'd0);
    chk("t3_addr", Inst_Adress, 64'd4);
    cyc();
    head("t3_h", I1, 64'd4);

    // Test 4: misaligned redirect faults, aligned redirect recovers
    redirect_valid = 1'b1;
    redirect_pc = 64'd6;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("t4_fault", 64'(fault), 64'd1);
    chk("t4_empty", 64'(if_valid), 64'd0);
    chk("t4_addr", Inst_Adress, 64'd8);
    cyc();
    chk("t4_nopush", 64'(if_valid), 64'd0);
    chk("t4_sticky", 64'(fault), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'd0;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("t4_clear", 64'(fault), 64'd0);
    cyc();
    head("t4_h0", I0, 64'd0);

    // Test 5: run to halt, then redirect to 8 from END
    cyc();
    head("t5_h1", I1, 64'd4);
    cyc();
    head("t5_h2", I2, 64'd8);
    cyc();
    chk("t5_halted", 64'(halted), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'd8;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("t5_unhalt", 64'(halted), 64'd0);
    cyc();
    head("t5_h8", I2, 64'd8);
    cyc();
    chk("t5_rehalt", 64'(halted), 64'd1);
    chk("t5_nvalid", 64'(if_valid), 64'd0);
    chk_count("t5_cnt", 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
